fare_acc: RTL and testbench

FARE_ACC -- requirements
Module: fare_acc

---
 rtl/taxi_pkg.sv | 21 ++
 rtl/sat_add.sv | 22 ++
 rtl/fare_acc.sv | 149 ++++++++++++++
 tb/tb_fare_acc.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/taxi_pkg.sv
// Shared state encoding, output widths and default tariff constants for the taxi fare logic.
package taxi_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StHold = 2'd2
  } state_e;

  localparam int unsigned FareW = 14;
  localparam int unsigned DistW = 10;
  localparam int unsigned WaitW = 8;

  localparam int unsigned DefBaseFare = 130;
  localparam int unsigned DefFreeDist = 6;
  localparam int unsigned DefDistRate = 10;
  localparam int unsigned DefFreeWait = 3;
  localparam int unsigned DefWaitRate = 5;
  localparam int unsigned DefMaxFare  = 9999;

endpackage

// File: rtl/sat_add.sv
// Combinational add that clamps to Limit; the sum is formed one bit wider than the operands.
module sat_add #(
  parameter int unsigned Width = 8,
  parameter int unsigned Limit = 255
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  output logic [Width-1:0] sum_o,
  output logic             sat_o
);

  localparam logic [Width:0] LimitW = (Width + 1)'(Limit);

  logic [Width:0] sum_full;

  always_comb begin
    sum_full = {1'b0, a_i} + {1'b0, b_i};
    sat_o    = (sum_full >= LimitW);
    sum_o    = sat_o ? LimitW[Width-1:0] : sum_full[Width-1:0];
  end

endmodule

// File: rtl/fare_acc.sv
// Taxi fare accumulator: IDLE/RUN/HOLD trip FSM charging distance and waiting time past free allowances.
module fare_acc
  import taxi_pkg::*;
#(
  parameter int unsigned BASE_FARE = DefBaseFare,
  parameter int unsigned FREE_DIST = DefFreeDist,
  parameter int unsigned DIST_RATE = DefDistRate,
  parameter int unsigned FREE_WAIT = DefFreeWait,
  parameter int unsigned WAIT_RATE = DefWaitRate,
  parameter int unsigned MAX_FARE  = DefMaxFare
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             clr,
  input  logic             dist_pulse,
  input  logic             min_pulse,
  output logic [FareW-1:0] fare,
  output logic [DistW-1:0] dist_cnt,
  output logic [WaitW-1:0] wait_min,
  output logic             running,
  output logic             max
);

  localparam logic [FareW-1:0] BaseFare = FareW'(BASE_FARE);
  localparam logic [FareW-1:0] DistRate = FareW'(DIST_RATE);
  localparam logic [FareW-1:0] WaitRate = FareW'(WAIT_RATE);
  localparam logic [DistW-1:0] FreeDist = DistW'(FREE_DIST);
  localparam logic [WaitW-1:0] FreeWait = WaitW'(FREE_WAIT);

  state_e           state_q;
  logic [FareW-1:0] fare_q;
  logic [DistW-1:0] dist_cnt_q;
  logic [WaitW-1:0] wait_min_q;
  logic             running_q;
  logic             max_q;

  logic [FareW-1:0] fare_inc;
  logic [FareW-1:0] fare_sum;
  logic             fare_sat;
  logic [DistW-1:0] dist_sum;
  logic [WaitW-1:0] wait_sum;
  logic             unused_dist_sat;
  logic             unused_wait_sat;

  // Charges use the pre-increment counts, so the pulse that exhausts an allowance is still free.
  always_comb begin
    fare_inc = '0;
    if (dist_pulse && (dist_cnt_q >= FreeDist)) begin
      fare_inc = fare_inc + DistRate;
    end
    if (min_pulse && (wait_min_q >= FreeWait)) begin
      fare_inc = fare_inc + WaitRate;
    end
  end

  sat_add #(
    .Width(FareW),
    .Limit(MAX_FARE)
  ) u_fare_add (
    .a_i  (fare_q),
    .b_i  (fare_inc),
    .sum_o(fare_sum),
    .sat_o(fare_sat)
  );

  sat_add #(
    .Width(DistW),
    .Limit((1 << DistW) - 1)
  ) u_dist_add (
    .a_i  (dist_cnt_q),
    .b_i  ({{(DistW - 1){1'b0}}, dist_pulse}),
    .sum_o(dist_sum),
    .sat_o(unused_dist_sat)
  );

  sat_add #(
    .Width(WaitW),
    .Limit((1 << WaitW) - 1)
  ) u_wait_add (
    .a_i  (wait_min_q),
    .b_i  ({{(WaitW - 1){1'b0}}, min_pulse}),
    .sum_o(wait_sum),
    .sat_o(unused_wait_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      fare_q     <= '0;
      dist_cnt_q <= '0;
      wait_min_q <= '0;
      running_q  <= 1'b0;
      max_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q    <= StRun;
            fare_q     <= BaseFare;
            dist_cnt_q <= '0;
            wait_min_q <= '0;
            running_q  <= 1'b1;
            max_q      <= 1'b0;
          end
        end
        StRun: begin
          // Pulses coinciding with stop still land before the freeze.
          fare_q     <= fare_sum;
          dist_cnt_q <= dist_sum;
          wait_min_q <= wait_sum;
          max_q      <= max_q | fare_sat;
          if (stop) begin
            state_q   <= StHold;
            running_q <= 1'b0;
          end
        end
        StHold: begin
          if (start) begin
            state_q    <= StRun;
            fare_q     <= BaseFare;
            dist_cnt_q <= '0;
            wait_min_q <= '0;
            running_q  <= 1'b1;
            max_q      <= 1'b0;
          end else if (clr) begin
            state_q    <= StIdle;
            fare_q     <= '0;
            dist_cnt_q <= '0;
            wait_min_q <= '0;
            max_q      <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign fare     = fare_q;
  assign dist_cnt = dist_cnt_q;
  assign wait_min = wait_min_q;
  assign running  = running_q;
  assign max      = max_q;

endmodule

// File: tb/tb_fare_acc.sv
// Directed self-checking bench for fare_acc with hand-computed expected values at default tariffs.
module tb_fare_acc;
  import taxi_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic        clr;
  logic        dist_pulse;
  logic        min_pulse;
  logic [13:0] fare;
  logic [9:0]  dist_cnt;
  logic [7:0]  wait_min;
  logic        running;
  logic        max;

  int passed;
  int failed;
  int total;

  fare_acc dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .clr       (clr),
    .dist_pulse(dist_pulse),
    .min_pulse (min_pulse),
    .fare      (fare),
    .dist_cnt  (dist_cnt),
    .wait_min  (wait_min),
    .running   (running),
    .max       (max)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock with the given one-cycle inputs; returns #1 after the edge for sampling.
  task automatic cyc(input logic s, input logic p, input logic c, input logic d, input logic m);
    start      = s;
    stop       = p;
    clr        = c;
    dist_pulse = d;
    min_pulse  = m;
    @(posedge clk);
    #1;
    start      = 1'b0;
    stop       = 1'b0;
    clr        = 1'b0;
    dist_pulse = 1'b0;
    min_pulse  = 1'b0;
  endtask

  initial begin
    passed = 0;
    failed = 0;
    total  = 0;
    rst_n  = 1'b0;
    start = 1'b0; stop = 1'b0; clr = 1'b0; dist_pulse = 1'b0; min_pulse = 1'b0;

    // Reset, with inputs active to show they are ignored
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("rst_fare", fare, 0);
    check("rst_dist", dist_cnt, 0);
    check("rst_wait", wait_min, 0);
    check("rst_running", running, 0);
    check("rst_max", max, 0);
    rst_n = 1'b1;

    // IDLE ignores stop, clr and pulses
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    check("idle_ignore_fare", fare, 0);
    check("idle_ignore_running", running, 0);

    // Start, 10 distance pulses: 130 + 4*10
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("start_fare", fare, 130);
    check("start_running", running, 1);
    repeat (10) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("d10_fare", fare, 170);
    check("d10_dist", dist_cnt, 10);
    check("d10_running", running, 1);
    check("d10_max", max, 0);

    // 5 waiting minutes: 2 chargeable -> +10
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("m5_fare", fare, 180);
    check("m5_wait", wait_min, 5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check("stop_running", running, 0);
    check("stop_fare", fare, 180);

    // HOLD freezes everything
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("hold_fare", fare, 180);
    check("hold_dist", dist_cnt, 10);
    check("hold_wait", wait_min, 5);
    check("hold_running", running, 0);

    // Restart from HOLD with a coincident pulse, which must be ignored
    cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    check("restart_fare", fare, 130);
    check("restart_dist", dist_cnt, 0);
    check("restart_wait", wait_min, 0);
    check("restart_running", running, 1);

    // Exhaust both allowances, then coincident pulses: +10 +5
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("allow_fare", fare, 130);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("both_fare", fare, 145);
    check("both_dist", dist_cnt, 7);
    check("both_wait", wait_min, 4);

    // start and clr ignored in RUN
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("run_ignore_fare", fare, 145);
    check("run_ignore_running", running, 1);

    // Pulse with stop is counted
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    check("stop_pulse_fare", fare, 155);
    check("stop_pulse_dist", dist_cnt, 8);
    check("stop_pulse_running", running, 0);

    // clr in HOLD returns to IDLE
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("clr_fare", fare, 0);
    check("clr_dist", dist_cnt, 0);
    check("clr_wait", wait_min, 0);
    check("clr_state", dut.state_q, StIdle);

    // start+stop in IDLE enters RUN; start+stop in RUN enters HOLD
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("idle_ss_running", running, 1);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("run_ss_running", running, 0);
    check("run_ss_state", dut.state_q, StHold);
    // start wins over clr in HOLD
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    check("hold_sc_running", running, 1);
    check("hold_sc_fare", fare, 130);

    // Saturation: 992 pulses -> 130 + 986*10 = 9990, 993rd -> 10000 clamps to 9999
    repeat (992) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("pre_sat_fare", fare, 9990);
    check("pre_sat_max", max, 0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("sat_fare", fare, 9999);
    check("sat_max", max, 1);
    check("sat_dist", dist_cnt, 993);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    check("post_sat_fare", fare, 9999);
    check("post_sat_dist", dist_cnt, 994);
    check("post_sat_wait", wait_min, 1);
    check("post_sat_max", max, 1);

    // Reload clears max
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("reload_max", max, 0);
    check("reload_fare", fare, 130);

    // Reach 500 mid-trip (6 free + 37 charged), then reset
    repeat (43) cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check("mid_fare", fare, 500);
    rst_n = 1'b0;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    check("midrst_fare", fare, 0);
    check("midrst_dist", dist_cnt, 0);
    check("midrst_wait", wait_min, 0);
    check("midrst_running", running, 0);
    check("midrst_max", max, 0);
    check("midrst_state", dut.state_q, StIdle);
    rst_n = 1'b1;

    // start+stop in the same RUN cycle, then clr
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("ss_hold_state", dut.state_q, StHold);
    check("ss_hold_fare", fare, 130);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("final_clr_fare", fare, 0);
    check("final_clr_running", running, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
